// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel colour type, FSM state type, default 640x480
// timing and the line/frame total helpers used by generator and receiver.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOCKED
  } rx_state_t;

  localparam int unsigned DEF_HWIDTH  = 640;
  localparam int unsigned DEF_HFPORCH = 16;
  localparam int unsigned DEF_HSYNC   = 96;
  localparam int unsigned DEF_HBPORCH = 48;
  localparam int unsigned DEF_VWIDTH  = 480;
  localparam int unsigned DEF_VFPORCH = 11;
  localparam int unsigned DEF_VSYNC   = 2;
  localparam int unsigned DEF_VBPORCH = 31;

  function automatic int unsigned h_total(input int unsigned width, input int unsigned fporch,
                                          input int unsigned sync, input int unsigned bporch);
    return width + fporch + sync + bporch;
  endfunction

  function automatic int unsigned v_total(input int unsigned width, input int unsigned fporch,
                                          input int unsigned sync, input int unsigned bporch);
    return width + fporch + sync + bporch;
  endfunction

endpackage

// File: rtl/vga_rx_sync_det.sv
// Sync edge detector: recovers HS/VS falls, the horizontal counter hc, the
// line index k and line/frame length mismatch flags from registered syncs.
module vga_rx_sync_det #(
  parameter int unsigned HTOTAL = 800,
  parameter int unsigned VTOTAL = 524,
  parameter int unsigned HCW    = $clog2(HTOTAL),
  parameter int unsigned KW     = $clog2(VTOTAL + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hs,
  input  logic           vs,
  output logic           hs_fall,
  output logic           vs_fall,
  output logic [HCW-1:0] hc,
  output logic [KW-1:0]  k,
  output logic           line_mis,
  output logic           frame_mis
);

  localparam logic [HCW-1:0] HC_LAST = HCW'(HTOTAL - 1);

  logic           hs_prev, vs_prev, seen, vs_pend;
  logic [HCW-1:0] hc_q;
  logic [KW-1:0]  k_q, fcnt_q, fcnt_inc;

  assign hs_fall = hs_prev & ~hs;
  assign vs_fall = vs_prev & ~vs;

  // hc/k are the values belonging to the current S1 sample; a VS fall that
  // coincides with an HS fall is seen first, so k restarts on that same fall.
  always_comb begin
    hc = hc_q;
    if (hs_fall)
      hc = '0;
    else if (hc_q != HC_LAST)
      hc = hc_q + 1'b1;

    k = k_q;
    if (hs_fall) begin
      if (vs_pend || vs_fall)
        k = '0;
      else if (k_q != '1)
        k = k_q + 1'b1;
    end

    fcnt_inc = fcnt_q;
    if (hs_fall && fcnt_q != '1)
      fcnt_inc = fcnt_q + 1'b1;

    line_mis  = seen && (hc_q != HC_LAST);
    frame_mis = (fcnt_inc != KW'(VTOTAL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      seen    <= 1'b0;
      vs_pend <= 1'b0;
      hc_q    <= '0;
      k_q     <= '0;
      fcnt_q  <= '0;
    end else begin
      hs_prev <= hs;
      vs_prev <= vs;
      seen    <= seen | hs_fall;
      hc_q    <= hc;
      k_q     <= k;
      fcnt_q  <= vs_fall ? '0 : fcnt_inc;
      if (hs_fall)
        vs_pend <= 1'b0;
      else if (vs_fall)
        vs_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_rx.sv
// vga_rx: VGA sink that verifies HS/VS timing and, once locked, emits a
// coordinate-tagged pixel stream. Define VGA_RX_STATS_EN for frame/error counters.
module vga_rx
  import vga_pkg::*;
#(
  parameter int unsigned HWIDTH  = DEF_HWIDTH,
  parameter int unsigned HFPORCH = DEF_HFPORCH,
  parameter int unsigned HSYNC   = DEF_HSYNC,
  parameter int unsigned HBPORCH = DEF_HBPORCH,
  parameter int unsigned VWIDTH  = DEF_VWIDTH,
  parameter int unsigned VFPORCH = DEF_VFPORCH,
  parameter int unsigned VSYNC   = DEF_VSYNC,
  parameter int unsigned VBPORCH = DEF_VBPORCH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                VGA_R,
  input  logic [3:0]                VGA_G,
  input  logic [3:0]                VGA_B,
  input  logic                      VGA_HS,
  input  logic                      VGA_VS,
  output logic                      pixel_valid,
  output logic [$clog2(HWIDTH)-1:0] pixel_x,
  output logic [$clog2(VWIDTH)-1:0] pixel_y,
  output logic [11:0]               pixel_rgb,
  output logic                      sof,
  output logic                      eol,
  output logic                      locked,
  output logic                      sync_err,
  output logic [15:0]               frame_cnt,
  output logic [7:0]                err_cnt
);

  localparam int unsigned HTOTAL = h_total(HWIDTH, HFPORCH, HSYNC, HBPORCH);
  localparam int unsigned VTOTAL = v_total(VWIDTH, VFPORCH, VSYNC, VBPORCH);
  localparam int unsigned HCW    = $clog2(HTOTAL);
  localparam int unsigned KW     = $clog2(VTOTAL + 1);
  localparam int unsigned XW     = $clog2(HWIDTH);
  localparam int unsigned YW     = $clog2(VWIDTH);

  localparam logic [HCW-1:0] X_LO = HCW'(HSYNC + HBPORCH);
  localparam logic [HCW-1:0] X_HI = HCW'(HSYNC + HBPORCH + HWIDTH);
  localparam logic [KW-1:0]  Y_LO = KW'(VSYNC + VBPORCH - 1);
  localparam logic [KW-1:0]  Y_HI = KW'(VSYNC + VBPORCH - 1 + VWIDTH);

  rgb444_t        rgb_s1;
  logic           hs_s1, vs_s1;
  logic           hs_fall, vs_fall, line_mis, frame_mis;
  logic [HCW-1:0] hc;
  logic [KW-1:0]  k;
  rx_state_t      state_q, state_d;
  logic           err, pix_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1 <= '0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
    end else begin
      rgb_s1 <= '{r: VGA_R, g: VGA_G, b: VGA_B};
      hs_s1  <= VGA_HS;
      vs_s1  <= VGA_VS;
    end
  end

  vga_rx_sync_det #(
    .HTOTAL (HTOTAL),
    .VTOTAL (VTOTAL),
    .HCW    (HCW),
    .KW     (KW)
  ) u_sync_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .hs        (hs_s1),
    .vs        (vs_s1),
    .hs_fall   (hs_fall),
    .vs_fall   (vs_fall),
    .hc        (hc),
    .k         (k),
    .line_mis  (line_mis),
    .frame_mis (frame_mis)
  );

  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: if (vs_fall) state_d = ST_CHECK;
      ST_CHECK, ST_LOCKED: begin
        if ((hs_fall && line_mis) || (vs_fall && frame_mis)) begin
          err     = 1'b1;
          state_d = vs_fall ? ST_CHECK : ST_IDLE;
        end else if (vs_fall) begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pix_act = (state_q == ST_LOCKED) && (hc >= X_LO) && (hc < X_HI) && (k >= Y_LO) && (k < Y_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked      <= (state_d == ST_LOCKED);
      sync_err    <= err;
      pixel_valid <= pix_act;
      sof         <= pix_act && (hc == X_LO) && (k == Y_LO);
      eol         <= pix_act && (hc == X_HI - 1'b1);
      if (pix_act) begin
        pixel_x   <= XW'(hc - X_LO);
        pixel_y   <= YW'(k - Y_LO);
        pixel_rgb <= rgb_s1;
      end
    end
  end

`ifdef VGA_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (vs_fall && state_q == ST_LOCKED)
        frame_cnt <= frame_cnt + 1'b1;
      if (err && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx on a reduced 8x6 mode: a generator drives whole frames from a
// table of scenarios; a scoreboard queue checks every emitted pixel and its latency.
module tb_vga_rx;

  localparam int unsigned HW = 8, HFP = 2, HSY = 3, HBP = 3;
  localparam int unsigned VW = 6, VFP = 2, VSY = 2, VBP = 3;
`ifdef VGA_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic        VGA_HS = 1'b1, VGA_VS = 1'b1;
  logic        pixel_valid, sof, eol, locked, sync_err;
  logic [2:0]  pixel_x, pixel_y;
  logic [11:0] pixel_rgb;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  vga_rx #(
    .HWIDTH (HW), .HFPORCH (HFP), .HSYNC (HSY), .HBPORCH (HBP),
    .VWIDTH (VW), .VFPORCH (VFP), .VSYNC (VSY), .VBPORCH (VBP)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B), .VGA_HS (VGA_HS), .VGA_VS (VGA_VS),
    .pixel_valid (pixel_valid), .pixel_x (pixel_x), .pixel_y (pixel_y), .pixel_rgb (pixel_rgb),
    .sof (sof), .eol (eol), .locked (locked), .sync_err (sync_err),
    .frame_cnt (frame_cnt), .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // mode: 0 normal, 1 one 15-cycle line, 2 twelve-line frame,
  //       3 VS falls with HS, 4 as 3 plus reset at line 3 column 4
  typedef struct {
    int          mode;
    bit          solid;
    logic [15:0] c565;
    logic [11:0] exp_rgb;
    bit          lock_vis;
    int          pix;
    int          errs;
    bit          lock_end;
    int          fcnt;
    int          ecnt;
  } vec_t;

  typedef struct {
    int         due;
    logic [2:0] x;
    logic [2:0] y;
    logic [11:0] rgb;
    logic       sof;
    logic       eol;
  } exp_t;

  vec_t tbl[13];
  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   cyc = 0, err_seen = 0, pix_seen = 0;
  bit   lock_vis = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sync_err) err_seen++;
    if (pixel_valid) pix_seen++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      chk("pix_valid", 32'(pixel_valid), 1);
      chk("pix_x", 32'(pixel_x), 32'(mon_e.x));
      chk("pix_y", 32'(pixel_y), 32'(mon_e.y));
      chk("pix_rgb", 32'(pixel_rgb), 32'(mon_e.rgb));
      chk("pix_sof_eol", {30'd0, sof, eol}, {30'd0, mon_e.sof, mon_e.eol});
    end else if (pixel_valid) begin
      chk("pix_unexpected", 32'(pixel_valid), 0);
    end
  end

  task automatic drive(input logic h, input logic v, input logic [11:0] c, input bit vis,
                       input logic [11:0] erg, input int x, input int y);
    exp_t e;
    VGA_HS = h;
    VGA_VS = v;
    {VGA_R, VGA_G, VGA_B} = c;
    if (vis && lock_vis) begin
      e.due = cyc + 2;
      e.x   = 3'(x);
      e.y   = 3'(y);
      e.rgb = erg;
      e.sof = (x == 0) && (y == 0);
      e.eol = (x == HW - 1);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int          nl, vl, len;
    logic        hsv, vsv;
    logic [11:0] c, erg;
    bit          vis;
    nl       = (v.mode == 2) ? 12 : 13;
    lock_vis = v.lock_vis;
    err_seen = 0;
    pix_seen = 0;
    for (int li = 0; li < nl; li++) begin
      vl  = (v.mode == 2 && li >= 7) ? li + 1 : li;
      len = (v.mode == 1 && vl == 6) ? 15 : 16;
      for (int h = 0; h < len; h++) begin
        if (v.mode == 4 && vl == 3 && h == 4) begin
          rst_n = 1'b0;
          sbq.delete();
          lock_vis = 1'b0;
          #1;
          chk("rst_mid_outs", {9'd0, pixel_valid, sof, eol, locked, sync_err, pixel_x, pixel_y, pixel_rgb}, 0);
          chk("rst_mid_stats", {8'd0, frame_cnt, err_cnt}, 0);
        end
        if (v.mode == 4 && vl == 3 && h == 8) rst_n = 1'b1;
        hsv = !(h >= 10 && h < 13);
        if (v.mode >= 3) vsv = !((vl == 8 && h >= 10) || vl == 9 || (vl == 10 && h < 10));
        else             vsv = !(vl == 8 || vl == 9);
        vis = (vl < VW) && (h < HW);
        if (!vis)         c = 12'h000;
        else if (v.solid) c = {v.c565[15:12], v.c565[10:7], v.c565[4:1]};
        else              c = 12'($urandom_range(0, 4095));
        erg = v.solid ? v.exp_rgb : c;
        drive(hsv, vsv, c, vis, erg, h, vl);
      end
    end
    $display("frame %0d mode %0d: pixels %0d sync_err %0d locked %0b", idx, v.mode, pix_seen, err_seen, locked);
    chk("frame_pix", pix_seen, v.pix);
    chk("frame_errs", err_seen, v.errs);
    chk("frame_sb_empty", sbq.size(), 0);
    chk("frame_locked", 32'(locked), 32'(v.lock_end));
    chk("frame_cnt", 32'(frame_cnt), STATS ? v.fcnt : 0);
    chk("err_cnt", 32'(err_cnt), STATS ? v.ecnt : 0);
  endtask

  initial begin
    //          mode solid c565      exp_rgb  vis pix  err lock fcnt ecnt
    tbl[0]  = '{0,   0,    16'h0000, 12'h000, 0,  0,   0,  0,   0,   0};
    tbl[1]  = '{0,   0,    16'h0000, 12'h000, 0,  0,   0,  1,   0,   0};
    tbl[2]  = '{0,   1,    16'h2FE0, 12'h2F0, 1,  48,  0,  1,   1,   0};
    tbl[3]  = '{1,   0,    16'h0000, 12'h000, 1,  48,  1,  0,   1,   1};
    tbl[4]  = '{0,   0,    16'h0000, 12'h000, 0,  0,   0,  1,   1,   1};
    tbl[5]  = '{2,   0,    16'h0000, 12'h000, 1,  48,  1,  0,   2,   2};
    tbl[6]  = '{0,   0,    16'h0000, 12'h000, 0,  0,   0,  1,   2,   2};
    tbl[7]  = '{0,   0,    16'h0000, 12'h000, 1,  48,  0,  1,   3,   2};
    tbl[8]  = '{4,   0,    16'h0000, 12'h000, 1,  26,  0,  0,   0,   0};
    tbl[9]  = '{3,   0,    16'h0000, 12'h000, 0,  0,   0,  1,   0,   0};
    tbl[10] = '{3,   0,    16'h0000, 12'h000, 1,  48,  0,  1,   1,   0};
    tbl[11] = '{3,   1,    16'hF81F, 12'hF0F, 1,  48,  0,  1,   2,   0};
    tbl[12] = '{3,   0,    16'h0000, 12'h000, 1,  48,  0,  1,   3,   0};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outs", {9'd0, pixel_valid, sof, eol, locked, sync_err, pixel_x, pixel_y, pixel_rgb}, 0);
    chk("reset_stats", {8'd0, frame_cnt, err_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_frame(tbl[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
